// File: rtl/stepper_move_sequencer.sv
`timescale 1ns/1ps
// Stepper move sequencer: accepts move commands, ramps the step rate, holds torque, drives {ENB,ENA,IN4..IN1}.
// Build option: define STEPPER_HALF_STEP_EN for the 8-entry half-step phase table (default is 4-entry full-step).
module stepper_move_sequencer #(
  parameter int unsigned STEPS_W      = 16,
  parameter int unsigned PERIOD_W     = 20,
  parameter int unsigned POS_W        = 24,
  parameter int unsigned START_PERIOD = 500000,
  parameter int unsigned MIN_PERIOD   = 25000,
  parameter int unsigned RAMP_DEC     = 25000,
  parameter int unsigned HOLD_CYCLES  = 5000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [STEPS_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [5:0]          motor_out,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [POS_W-1:0]    position
);

`ifdef STEPPER_HALF_STEP_EN
  localparam int unsigned IDX_W = 3;
`else
  localparam int unsigned IDX_W = 2;
`endif
  localparam int unsigned HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  localparam logic [PERIOD_W-1:0] START_P = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] MIN_P   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] DEC_P   = PERIOD_W'(RAMP_DEC);
  localparam logic [PERIOD_W:0]   DEC_X   = (PERIOD_W+1)'(RAMP_DEC);
  localparam logic [HOLD_W-1:0]   HOLD_P  = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD
  } state_e;

  function automatic logic [3:0] phase_pattern(input logic [IDX_W-1:0] i);
    logic [3:0] p;
`ifdef STEPPER_HALF_STEP_EN
    case (i)
      3'd0:    p = 4'b0001;
      3'd1:    p = 4'b0011;
      3'd2:    p = 4'b0010;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0100;
      3'd5:    p = 4'b1100;
      3'd6:    p = 4'b1000;
      default: p = 4'b1001;
    endcase
`else
    case (i)
      2'd0:    p = 4'b0011;
      2'd1:    p = 4'b0110;
      2'd2:    p = 4'b1100;
      default: p = 4'b1001;
    endcase
`endif
    return p;
  endfunction

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic [PERIOD_W-1:0] tgt_q, tgt_d;
  logic [PERIOD_W-1:0] cur_q, cur_d;
  logic [STEPS_W-1:0]  rem_q, rem_d;
  logic [STEPS_W-1:0]  rc_q, rc_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;

  logic                accept;
  logic                step;
  logic                finish;
  logic [STEPS_W-1:0]  rem_dec;
  logic [PERIOD_W:0]   cur_up;
  logic [PERIOD_W-1:0] cmd_tgt;
  logic [PERIOD_W-1:0] cmd_cur;

  assign cmd_ready = (state_q != ST_RUN) && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_tgt   = (cmd_period < MIN_P) ? MIN_P : cmd_period;
  assign cmd_cur   = (START_P > cmd_tgt) ? START_P : cmd_tgt;
  assign rem_dec   = rem_q - STEPS_W'(1);
  assign cur_up    = {1'b0, cur_q} + DEC_X;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    rem_d     = rem_q;
    rc_d      = rc_q;
    timer_d   = timer_q;
    hold_d    = hold_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;
    step      = 1'b0;
    finish    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        timer_d = timer_q - PERIOD_W'(1);
        step    = (timer_q <= PERIOD_W'(1));
        if (step) begin
          idx_d = dir_q ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
          pos_d = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
          rem_d = rem_dec;
          // rc counts ramp-up steps taken, so decel starts once remaining steps fit the ramp back down
          if ((rem_dec <= rc_q) && (rc_q != '0)) begin
            cur_d = (cur_up > {1'b0, START_P}) ? START_P : cur_up[PERIOD_W-1:0];
            rc_d  = rc_q - STEPS_W'(1);
          end else if (cur_q > tgt_q) begin
            cur_d = ({1'b0, cur_q} > ({1'b0, tgt_q} + DEC_X)) ? cur_q - DEC_P : tgt_q;
            rc_d  = rc_q + STEPS_W'(1);
          end
          timer_d = cur_d;
          finish  = (rem_dec == '0);
        end
        if (abort) begin
          finish    = 1'b1;
          aborted_d = 1'b1;
        end
        if (finish) begin
          state_d = ST_HOLD;
          done_d  = 1'b1;
          hold_d  = HOLD_P;
        end
      end
      ST_HOLD: begin
        if (hold_q <= HOLD_W'(1)) state_d = ST_IDLE;
        else                      hold_d  = hold_q - HOLD_W'(1);
      end
      default: ;
    endcase

    // Accept is only possible outside RUN, so it never races the step logic above
    if (accept) begin
      aborted_d = 1'b0;
      if (cmd_steps == '0) begin
        done_d = 1'b1;
      end else begin
        state_d = ST_RUN;
        dir_d   = cmd_dir;
        tgt_d   = cmd_tgt;
        cur_d   = cmd_cur;
        rem_d   = cmd_steps;
        rc_d    = '0;
        timer_d = cmd_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      tgt_q     <= '0;
      cur_q     <= '0;
      rem_q     <= '0;
      rc_q      <= '0;
      timer_q   <= '0;
      hold_q    <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      rem_q     <= rem_d;
      rc_q      <= rc_d;
      timer_q   <= timer_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign motor_out = (state_q == ST_IDLE) ? 6'b000000 : {2'b11, phase_pattern(idx_q)};
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign position  = pos_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
`timescale 1ns/1ps
// Bench for stepper_move_sequencer: directed and random moves against a step-schedule reference model.
module tb_stepper_move_sequencer;
  localparam int unsigned STEPS_W  = 16;
  localparam int unsigned PERIOD_W = 20;
  localparam int unsigned POS_W    = 24;
  localparam int START_P  = 20;
  localparam int MIN_P    = 4;
  localparam int RAMP     = 4;
  localparam int HOLD     = 10;
  localparam int POS_MASK = (1 << POS_W) - 1;

  logic                clk = 1'b0;
  logic                reset;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [STEPS_W-1:0]  cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;
  logic                abort;
  logic [5:0]          motor_out;
  logic                busy;
  logic                done;
  logic                aborted;
  logic [POS_W-1:0]    position;

  int checks   = 0;
  int failures = 0;
  int m_pos    = 0;
  int m_idx    = 0;
  bit m_idle   = 1'b1;
  int tbl[4]   = '{3, 6, 12, 9};

  always #5 clk = ~clk;

  stepper_move_sequencer #(
    .STEPS_W      (STEPS_W),
    .PERIOD_W     (PERIOD_W),
    .POS_W        (POS_W),
    .START_PERIOD (START_P),
    .MIN_PERIOD   (MIN_P),
    .RAMP_DEC     (RAMP),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .motor_out  (motor_out),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .position   (position)
  );

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Enters and leaves at 2 time units after a rising edge.
  task automatic check_reset_state(input string tag);
    expect_eq({tag, "_motor"},   32'(motor_out), 0);
    expect_eq({tag, "_ready"},   32'(cmd_ready), 1);
    expect_eq({tag, "_pos"},     32'(position),  0);
    expect_eq({tag, "_busy"},    32'(busy),      0);
    expect_eq({tag, "_done"},    32'(done),      0);
    expect_eq({tag, "_aborted"}, 32'(aborted),   0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    m_pos  = 0;
    m_idx  = 0;
    m_idle = 1'b1;
  endtask

  // abort_at: edge offset after the accept edge at which abort is sampled (0 = never).
  // watch: cycles observed after the move ends before returning.
  task automatic run_move(input bit dir, input int steps, input int period,
                          input int abort_at, input int watch);
    int t[$];
    int tgt, cur, rc, rem, tm, last_t, fin, k, sgn, last_c, eidx, emot;
    bit was_abort;
    tgt = (period < MIN_P) ? MIN_P : period;
    cur = (tgt > START_P) ? tgt : START_P;
    rc  = 0;
    tm  = 0;
    for (int i = 1; i <= steps; i++) begin
      tm += cur;
      t.push_back(tm);
      rem = steps - i;
      if (rem <= rc && rc > 0) begin
        cur = (cur + RAMP > START_P) ? START_P : cur + RAMP;
        rc--;
      end else if (cur > tgt) begin
        cur = (cur - RAMP < tgt) ? tgt : cur - RAMP;
        rc++;
      end
    end
    last_t    = t[$];
    was_abort = (abort_at > 0) && (abort_at <= last_t);
    fin       = was_abort ? abort_at : last_t;
    sgn       = dir ? 1 : -1;
    last_c    = fin + watch;
    k         = 0;

    cmd_dir    = dir;
    cmd_steps  = STEPS_W'(steps);
    cmd_period = PERIOD_W'(period);
    cmd_valid  = 1'b1;
    #1 expect_eq("ready_at_accept", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    for (int c = 0; c <= last_c; c++) begin
      abort     = (c + 1 == abort_at);
      cmd_valid = abort;
      cmd_steps = STEPS_W'(3);
      #1;
      k = 0;
      foreach (t[i]) if (t[i] <= c && t[i] <= fin) k++;
      eidx = (((m_idx + sgn * k) % 4) + 4) % 4;
      emot = (c < fin + HOLD) ? (48 + tbl[eidx]) : 0;
      expect_eq("position",  32'(position),  (m_pos + sgn * k) & POS_MASK);
      expect_eq("motor_out", 32'(motor_out), emot);
      expect_eq("busy",      32'(busy),      (c < fin) ? 1 : 0);
      expect_eq("done",      32'(done),      (c == fin) ? 1 : 0);
      expect_eq("aborted",   32'(aborted),   (was_abort && c >= fin) ? 1 : 0);
      expect_eq("cmd_ready", 32'(cmd_ready), (c >= fin && !abort) ? 1 : 0);
      if (c < last_c) begin
        @(posedge clk);
        #1;
      end
    end
    abort     = 1'b0;
    cmd_valid = 1'b0;
    m_pos     = m_pos + sgn * k;
    m_idx     = (((m_idx + sgn * k) % 4) + 4) % 4;
    m_idle    = (watch >= HOLD);
  endtask

  task automatic zero_step();
    cmd_valid  = 1'b1;
    cmd_steps  = '0;
    cmd_dir    = 1'($urandom_range(0, 1));
    cmd_period = PERIOD_W'($urandom_range(0, 30));
    #1 expect_eq("zero_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    #1;
    expect_eq("zero_done",    32'(done),      1);
    expect_eq("zero_motor",   32'(motor_out), 0);
    expect_eq("zero_pos",     32'(position),  m_pos & POS_MASK);
    expect_eq("zero_aborted", 32'(aborted),   0);
    expect_eq("zero_busy",    32'(busy),      0);
    @(posedge clk);
    #2;
    expect_eq("zero_done_end", 32'(done),      0);
    expect_eq("zero_motor_end", 32'(motor_out), 0);
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_steps  = '0;
    cmd_period = '0;
    abort      = 1'b0;

    do_reset(3);
    check_reset_state("rst");

    // Reset while a move is running
    cmd_dir    = 1'b1;
    cmd_steps  = STEPS_W'(5);
    cmd_period = PERIOD_W'(8);
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    expect_eq("midmove_busy", 32'(busy),     1);
    expect_eq("midmove_pos",  32'(position), 1);
    do_reset(1);
    check_reset_state("rst_mid");

    run_move(1'b1, 4, 20, 0, HOLD + 2);
    run_move(1'b1, 6, 8, 0, HOLD + 2);
    run_move(1'b1, 10, 20, 45, HOLD + 2);
    expect_eq("aborted_sticky", 32'(aborted), 1);
    zero_step();

    do_reset(2);
    check_reset_state("rst2");
    run_move(1'b0, 1, 20, 0, 3);
    run_move(1'b1, 1, 20, 0, HOLD + 2);

    for (int n = 0; n < 30; n++) begin
      bit d;
      int st, pr, ab, w;
      d  = 1'($urandom_range(0, 1));
      st = $urandom_range(1, 8);
      pr = $urandom_range(0, 30);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
      w  = ($urandom_range(0, 1) == 1) ? HOLD + 2 : $urandom_range(2, 6);
      if (m_idle && $urandom_range(0, 3) == 0) zero_step();
      run_move(d, st, pr, ab, w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
